// File: rtl/vmem_pkg.sv
// Shared definitions for the vector memory bank responder.
//   - FSM state encoding
//   - geometry constants (bank count, lanes, element width, row width)
//   - word-address helpers: bank_of() selects the bank, row_of() the row inside it
package vmem_pkg;

  localparam int unsigned NUM_BANKS = 4;
  localparam int unsigned LANES     = 16;
  localparam int unsigned ELEM_W    = 16;
  localparam int unsigned ROW_W     = 13;
  localparam int unsigned WORD_W    = 15;  // word address = byte address [15:1]
  localparam int unsigned LEN_W     = 5;
  localparam int unsigned LANE_IDX_W = 4;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StDrain,
    StWr,
    StResp
  } state_e;

  function automatic logic [1:0] bank_of(input logic [WORD_W-1:0] word);
    return word[1:0];
  endfunction

  function automatic logic [ROW_W-1:0] row_of(input logic [WORD_W-1:0] word);
    return word[WORD_W-1:2];
  endfunction

endpackage

// File: rtl/vmem_bank_responder_if.sv
// CPU-side request/response bus of the vector memory responder.
//   req_*: one vld/vst request (valid/ready), byte address, element count, store data
//   rsp_*: load result or store acknowledge (valid/ready)
// master = CPU side, slave = responder side.
interface vmem_bank_responder_if;
  import vmem_pkg::*;

  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic [15:0]               req_addr;
  logic [LEN_W-1:0]          req_len;
  logic [LANES*ELEM_W-1:0]   req_wdata;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic                      rsp_we;
  logic [LANES*ELEM_W-1:0]   rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_len, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_we, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_len, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_we, rsp_data
  );

endinterface

// File: rtl/vmem_lane_steer.sv
// Combinational bank/element steering for one beat.
//   base_i : word address of element 0
//   beat_i : beat index k (elements 4k..4k+3)
//   len_i  : effective element count L (0..16)
//   live_o : per-bank flag, bank holds an element < L in this beat
//   row_o  : per-bank row address of that element
//   lane_o : per-bank vector lane index of that element
module vmem_lane_steer
  import vmem_pkg::*;
(
  input  logic [WORD_W-1:0]                     base_i,
  input  logic [1:0]                            beat_i,
  input  logic [LEN_W-1:0]                      len_i,
  output logic [NUM_BANKS-1:0]                  live_o,
  output logic [NUM_BANKS-1:0][ROW_W-1:0]       row_o,
  output logic [NUM_BANKS-1:0][LANE_IDX_W-1:0]  lane_o
);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [1:0]        off;
    logic [LEN_W-1:0]  elem;
    logic [WORD_W-1:0] word;

    // Element offset inside the beat that lands on bank b.
    assign off       = 2'(b) - base_i[1:0];
    assign elem      = {1'b0, beat_i, off};
    assign word      = base_i + WORD_W'(elem);  // wraps modulo 2^15
    assign live_o[b] = elem < len_i;
    assign row_o[b]  = row_of(word);
    assign lane_o[b] = elem[LANE_IDX_W-1:0];
  end

endmodule

// File: rtl/vmem_bank_responder.sv
// Memory-side responder for vector loads/stores over four interleaved word banks.
//   clk, rst_n    : clock, synchronous active-low reset
//   cpu           : request/response bus (slave side)
//   bank_raddr_o  : per-bank read row, bank b at [13b+12:13b]
//   bank_rdata_i  : per-bank read data, one cycle after bank_raddr_o
//   bank_wen_o    : per-bank write enable
//   bank_waddr_o  : per-bank write row
//   bank_wdata_o  : per-bank write data
// One request at a time; up to four elements per cycle.
module vmem_bank_responder
  import vmem_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  vmem_bank_responder_if.slave        cpu,
  output logic [NUM_BANKS*ROW_W-1:0]  bank_raddr_o,
  input  logic [NUM_BANKS*ELEM_W-1:0] bank_rdata_i,
  output logic [NUM_BANKS-1:0]        bank_wen_o,
  output logic [NUM_BANKS*ROW_W-1:0]  bank_waddr_o,
  output logic [NUM_BANKS*ELEM_W-1:0] bank_wdata_o
);

  localparam int unsigned DataW = LANES * ELEM_W;

  state_e                                state_q, state_d;
  logic [WORD_W-1:0]                     word_q, word_d;
  logic [LEN_W-1:0]                      len_q, len_d;
  logic [DataW-1:0]                      wdata_q, wdata_d;
  logic                                  we_q, we_d;
  logic [1:0]                            beat_q, beat_d;
  logic [DataW-1:0]                      data_q, data_d;
  logic [NUM_BANKS*ROW_W-1:0]            raddr_q, raddr_d;
  logic [NUM_BANKS-1:0]                  cap_live_q, cap_live_d;
  logic [NUM_BANKS-1:0][LANE_IDX_W-1:0]  cap_lane_q;

  logic [NUM_BANKS-1:0]                  live;
  logic [NUM_BANKS-1:0][ROW_W-1:0]       row;
  logic [NUM_BANKS-1:0][LANE_IDX_W-1:0]  lane;

  logic             accept;
  logic             last_beat;
  logic [LEN_W-1:0] eff_len;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = cpu.req_addr[0];

  vmem_lane_steer u_steer (
    .base_i (word_q),
    .beat_i (beat_q),
    .len_i  (len_q),
    .live_o (live),
    .row_o  (row),
    .lane_o (lane)
  );

  assign cpu.req_ready = (state_q == StIdle);
  assign accept        = cpu.req_valid & cpu.req_ready;
  assign eff_len       = (cpu.req_len > LEN_W'(LANES)) ? LEN_W'(LANES) : cpu.req_len;
  // Beat k is the last one once 4k+4 covers the effective length.
  assign last_beat     = ({1'b0, beat_q, 2'b00} + LEN_W'(4)) >= len_q;

  assign cpu.rsp_valid = (state_q == StResp);
  assign cpu.rsp_we    = (state_q == StResp) & we_q;
  assign cpu.rsp_data  = data_q;

  // Next state and request capture.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    beat_d  = beat_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          word_d  = cpu.req_addr[15:1];
          len_d   = eff_len;
          wdata_d = cpu.req_wdata;
          we_d    = cpu.req_we;
          beat_d  = 2'd0;
          if (eff_len == '0)   state_d = StResp;
          else if (cpu.req_we) state_d = StWr;
          else                 state_d = StRd;
        end
      end
      StRd: begin
        if (last_beat) state_d = StDrain;
        else           beat_d  = beat_q + 2'd1;
      end
      StDrain: state_d = StResp;
      StWr: begin
        if (last_beat) state_d = StResp;
        else           beat_d  = beat_q + 2'd1;
      end
      StResp: begin
        if (cpu.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Bank drive: reads hold their row on idle banks, writes are zero when not live.
  always_comb begin
    bank_wen_o   = '0;
    bank_waddr_o = '0;
    bank_wdata_o = '0;
    raddr_d      = raddr_q;
    cap_live_d   = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (state_q == StWr && live[b]) begin
        bank_wen_o[b]                     = 1'b1;
        bank_waddr_o[b*ROW_W +: ROW_W]    = row[b];
        bank_wdata_o[b*ELEM_W +: ELEM_W]  = wdata_q[lane[b]*ELEM_W +: ELEM_W];
      end
      if (state_q == StRd && live[b]) begin
        raddr_d[b*ROW_W +: ROW_W] = row[b];
        cap_live_d[b]             = 1'b1;
      end
    end
  end
  assign bank_raddr_o = raddr_d;

  // Load result: cleared on accept, then filled one cycle after each read beat.
  always_comb begin
    data_d = data_q;
    if (accept) data_d = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (cap_live_q[b]) begin
        data_d[cap_lane_q[b]*ELEM_W +: ELEM_W] = bank_rdata_i[b*ELEM_W +: ELEM_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      word_q     <= '0;
      len_q      <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      beat_q     <= '0;
      data_q     <= '0;
      raddr_q    <= '0;
      cap_live_q <= '0;
      cap_lane_q <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      len_q      <= len_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      beat_q     <= beat_d;
      data_q     <= data_d;
      raddr_q    <= raddr_d;
      cap_live_q <= cap_live_d;
      cap_lane_q <= lane;
    end
  end

endmodule

// File: tb/tb_vmem_bank_responder.sv
// Directed bench for vmem_bank_responder with a four-bank memory model.
module tb_vmem_bank_responder;
  import vmem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vmem_bank_responder_if bus ();

  logic [NUM_BANKS*ROW_W-1:0]  bank_raddr, bank_waddr;
  logic [NUM_BANKS*ELEM_W-1:0] bank_rdata, bank_wdata;
  logic [NUM_BANKS-1:0]        bank_wen;

  vmem_bank_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu          (bus),
    .bank_raddr_o (bank_raddr),
    .bank_rdata_i (bank_rdata),
    .bank_wen_o   (bank_wen),
    .bank_waddr_o (bank_waddr),
    .bank_wdata_o (bank_wdata)
  );

  // Bank model: word w holds w until written; 1-cycle read latency.
  logic [15:0] mem [NUM_BANKS][8192];
  logic        init_mem = 1'b0;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int w = 0; w < 32768; w++) mem[bank_of(15'(w))][row_of(15'(w))] <= 16'(w);
    end else begin
      for (int b = 0; b < NUM_BANKS; b++)
        if (bank_wen[b]) mem[b][bank_waddr[b*ROW_W +: ROW_W]] <= bank_wdata[b*ELEM_W +: ELEM_W];
    end
    for (int b = 0; b < NUM_BANKS; b++)
      bank_rdata[b*ELEM_W +: ELEM_W] <= mem[b][bank_raddr[b*ROW_W +: ROW_W]];
  end

  int n_cmp = 0;
  int n_bad = 0;
  int lat;
  logic [3:0]  wen_hist   [0:47];
  logic [51:0] raddr_hist [0:47];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lane i = (first + i) mod 2^15 for i < n, zero above.
  function automatic logic [255:0] seq_data(input int first, input int n);
    logic [255:0] d;
    d = '0;
    for (int i = 0; i < n; i++) d[i*16 +: 16] = 16'((first + i) & 32'h7FFF);
    return d;
  endfunction

  function automatic logic [15:0] mem_word(input int w);
    return mem[bank_of(15'(w))][row_of(15'(w))];
  endfunction

  // Called #1 after the accept edge; counts cycles until rsp_valid.
  task automatic wait_rsp();
    lat = 1;
    while (1) begin
      wen_hist[lat]   = bank_wen;
      raddr_hist[lat] = bank_raddr;
      if (bus.rsp_valid || lat >= 40) break;
      @(posedge clk); #1;
      lat++;
    end
    chk("rsp_timeout", bus.rsp_valid, 1'b1);
  endtask

  task automatic run_req(input logic we, input logic [15:0] addr, input logic [4:0] len,
                         input logic [255:0] wd);
    int guard;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_len   = len;
    bus.req_wdata = wd;
    guard = 0;
    while (!bus.req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_timeout", guard < 100, 1'b1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_rsp();
  endtask

  task automatic ack();
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  logic [255:0] wd;
  logic [51:0]  raddr_before;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;

    // Reset and memory preload.
    init_mem = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    init_mem = 1'b0;
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_we", bus.rsp_we, 1'b0);
    chk("rst_rsp_data", bus.rsp_data, '0);
    chk("rst_wen", bank_wen, 4'b0000);
    chk("rst_raddr", bank_raddr, '0);
    chk("rst_waddr", bank_waddr, '0);
    chk("rst_wdata", bank_wdata, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Aligned load, 16 elements.
    run_req(1'b0, 16'h0000, 5'd16, '0);
    chk("aligned_lat", lat, 6);
    chk("aligned_beat0_rows", raddr_hist[1], {4{13'd0}});
    chk("aligned_beat1_rows", raddr_hist[2], {4{13'd1}});
    chk("aligned_data", bus.rsp_data, seq_data(0, 16));
    chk("aligned_rsp_we", bus.rsp_we, 1'b0);
    ack();

    // Unaligned load, W=3, 5 elements.
    run_req(1'b0, 16'h0006, 5'd5, '0);
    chk("unaligned_lat", lat, 4);
    chk("unaligned_beat0_rows", raddr_hist[1], {13'd0, 13'd1, 13'd1, 13'd1});
    chk("unaligned_data", bus.rsp_data, seq_data(3, 5));
    ack();

    // Wrap across the top of the address space.
    run_req(1'b0, 16'hFFFC, 5'd4, '0);
    chk("wrap_lat", lat, 3);
    chk("wrap_data", bus.rsp_data, {192'd0, 16'h0001, 16'h0000, 16'h7FFF, 16'h7FFE});
    ack();

    // Zero length: no bank access, immediate response.
    raddr_before = bank_raddr;
    run_req(1'b0, 16'h0100, 5'd0, '0);
    chk("len0_lat", lat, 1);
    chk("len0_wen", wen_hist[1], 4'b0000);
    chk("len0_raddr_hold", raddr_hist[1], raddr_before);
    chk("len0_data", bus.rsp_data, '0);
    ack();

    // Over-long request clamps to 16.
    run_req(1'b0, 16'h0000, 5'd20, '0);
    chk("len20_lat", lat, 6);
    chk("len20_data", bus.rsp_data, seq_data(0, 16));
    ack();

    // Store 6 elements at word 8.
    wd = '0;
    for (int i = 0; i < 16; i++) wd[i*16 +: 16] = 16'hA000 + 16'(i);
    run_req(1'b1, 16'h0010, 5'd6, wd);
    chk("store_lat", lat, 3);
    chk("store_wen_beat0", wen_hist[1], 4'b1111);
    chk("store_wen_beat1", wen_hist[2], 4'b0011);
    chk("store_rsp_we", bus.rsp_we, 1'b1);
    chk("store_rsp_data", bus.rsp_data, '0);
    ack();
    for (int w = 8; w < 14; w++) chk("store_mem", mem_word(w), 16'hA000 + 16'(w - 8));
    chk("store_mem_untouched", mem_word(14), 16'd14);

    // Backpressure with a queued request, then back-to-back accept.
    run_req(1'b0, 16'h0040, 5'd3, '0);
    chk("bp_lat", lat, 3);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 16'h0002;
    bus.req_len   = 5'd2;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_rsp_valid", bus.rsp_valid, 1'b1);
      chk("bp_rsp_data", bus.rsp_data, seq_data(32, 3));
      chk("bp_req_ready", bus.req_ready, 1'b0);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("b2b_idle_ready", bus.req_ready, 1'b1);
    chk("b2b_idle_rsp_valid", bus.rsp_valid, 1'b0);
    @(posedge clk); #1;
    chk("b2b_accepted", bus.req_ready, 1'b0);
    bus.req_valid = 1'b0;
    wait_rsp();
    chk("b2b_lat", lat, 3);
    chk("b2b_data", bus.rsp_data, seq_data(1, 2));
    ack();

    // Reset during store beat 1.
    wd = '0;
    for (int i = 0; i < 16; i++) wd[i*16 +: 16] = 16'hB000 + 16'(i);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 16'h0020;
    bus.req_len   = 5'd8;
    bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rstmid_beat0_wen", bank_wen, 4'b1111);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rstmid_wen", bank_wen, 4'b0000);
    chk("rstmid_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rstmid_req_ready", bus.req_ready, 1'b1);
    chk("rstmid_raddr", bank_raddr, '0);
    for (int w = 16; w < 20; w++) chk("rstmid_mem", mem_word(w), 16'hB000 + 16'(w - 16));
    repeat (3) begin
      @(posedge clk); #1;
      chk("rstmid_no_rsp", bus.rsp_valid, 1'b0);
    end

    // Recovery: read back the beat-0 words.
    run_req(1'b0, 16'h0020, 5'd4, '0);
    chk("recover_lat", lat, 3);
    chk("recover_data", bus.rsp_data, {192'd0, 16'hB003, 16'hB002, 16'hB001, 16'hB000});
    ack();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
